// File: rtl/bus_arbiter_n_pkg.sv
// Shared constants for the bus_arbiter_n block: FSM encodings and default widths.
package bus_arbiter_n_pkg;

  // Default bus widths inherited from the fixed 8-slave system bus
  localparam int WB_AddrBus   = 32;
  localparam int WB_DataBus   = 32;
  localparam int WB_SelectBus = WB_DataBus / 8;

  // FSM state encodings, kept as plain constants for legacy compatibility
  localparam logic [1:0] BUS_IDLE   = 2'd0;
  localparam logic [1:0] BUS_ACCESS = 2'd1;
  localparam logic [1:0] BUS_RESP   = 2'd2;

  // Width of the timeout counter: wide enough for TIMEOUT, never narrower than 8 bits
  function automatic int to_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/bus_arbiter_n_if.sv
// Master-side request/response and slave-side fan-out signals of bus_arbiter_n.
// modport master: the arbiter's own view (drives responses and slave strobes).
// modport slave : the surrounding system's view (drives requests and slave replies).
interface bus_arbiter_n_if #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic [ADDR_W-1:0]            m_addr_i;
  logic [DATA_W-1:0]            m_data_i;
  logic                         m_we_i;
  logic [SEL_W-1:0]             m_sel_i;
  logic                         m_stb_i;
  logic [DATA_W-1:0]            m_data_o;
  logic                         m_ack_o;
  logic                         m_err_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W-1:0]            s_data_o;
  logic                         s_we_o;
  logic [SEL_W-1:0]             s_sel_o;
  logic [NUM_SLAVES-1:0]        s_stb_o;
  logic [NUM_SLAVES*DATA_W-1:0] s_data_i;
  logic [NUM_SLAVES-1:0]        s_ack_i;

  modport master (
    input  m_addr_i, m_data_i, m_we_i, m_sel_i, m_stb_i, s_data_i, s_ack_i,
    output m_data_o, m_ack_o, m_err_o, s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o
  );

  modport slave (
    output m_addr_i, m_data_i, m_we_i, m_sel_i, m_stb_i, s_data_i, s_ack_i,
    input  m_data_o, m_ack_o, m_err_o, s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o
  );

endinterface

// File: rtl/bus_arbiter_n_addr_decode.sv
// bus_addr_decode: combinational slave-index decode of one address field.
// idx = addr[SEL_LSB +: SEL_BITS]; valid only when idx addresses an existing slave.
module bus_addr_decode #(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 8,
  parameter int SEL_LSB    = 28,
  parameter int SEL_BITS   = 3
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  valid
);

  logic [SEL_BITS-1:0] idx;
  logic                unused_addr;

  assign idx         = addr[SEL_LSB +: SEL_BITS];
  // Bits outside the index field are routed around this block on purpose
  assign unused_addr = ^addr;

  // One-hot select and range check; out-of-range indices strobe nothing
  always_comb begin
    onehot = '0;
    valid  = (int'(idx) < NUM_SLAVES);
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot[k] = (idx == SEL_BITS'(k));
    end
  end

endmodule

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: one master to NUM_SLAVES slaves, one registered transaction at a time.
// Optional feature macro: BUS_TIMEOUT_EN (adds an ACCESS timeout that returns an error).
module bus_arbiter_n
  import bus_arbiter_n_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = WB_AddrBus,
  parameter int DATA_W     = WB_DataBus,
  parameter int SEL_LSB    = 28,
  parameter int SEL_BITS   = 3,
  parameter int TIMEOUT    = 255
) (
  input logic            clk,
  input logic            rst,
  bus_arbiter_n_if.master bus
);

  localparam int SEL_W = DATA_W / 8;

  logic [1:0]            state;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  we_q;
  logic [SEL_W-1:0]      sel_q;
  logic [NUM_SLAVES-1:0] stb_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  ack_q;
  logic                  err_q;

  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  dec_valid;
  logic                  ack_hit;
  logic [DATA_W-1:0]     rd_mux;
  logic                  to_hit;

  bus_addr_decode #(
    .ADDR_W    (ADDR_W),
    .NUM_SLAVES(NUM_SLAVES),
    .SEL_LSB   (SEL_LSB),
    .SEL_BITS  (SEL_BITS)
  ) u_dec (
    .addr  (bus.m_addr_i),
    .onehot(dec_onehot),
    .valid (dec_valid)
  );

  // Only the strobed slave can complete the access; its read data is AND-OR muxed by the strobe
  always_comb begin
    ack_hit = |(bus.s_ack_i & stb_q);
    rd_mux  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (stb_q[k]) rd_mux = rd_mux | bus.s_data_i[k*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = to_cnt_width(TIMEOUT);
  logic [CNT_W-1:0] to_cnt;

  // Last strobe cycle is the one where the count has reached TIMEOUT-1
  assign to_hit = (to_cnt == CNT_W'(TIMEOUT - 1));

  // Counts unacknowledged ACCESS cycles; held at zero everywhere else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             to_cnt <= '0;
    else if (state != BUS_ACCESS)         to_cnt <= '0;
    else if (!ack_hit)                    to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign to_hit         = 1'b0;
  assign unused_timeout = |TIMEOUT;
`endif

  // Transaction FSM: latch in IDLE, strobe in ACCESS, one-cycle response in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= BUS_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      stb_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (bus.m_stb_i) begin
            addr_q  <= bus.m_addr_i;
            wdata_q <= bus.m_data_i;
            we_q    <= bus.m_we_i;
            sel_q   <= bus.m_sel_i;
            if (dec_valid) begin
              stb_q <= dec_onehot;
              state <= BUS_ACCESS;
            end else begin
              err_q <= 1'b1;
              state <= BUS_RESP;
            end
          end
        end
        BUS_ACCESS: begin
          // An ack in the timeout cycle takes precedence over the error
          if (ack_hit) begin
            rdata_q <= we_q ? '0 : rd_mux;
            ack_q   <= 1'b1;
            stb_q   <= '0;
            state   <= BUS_RESP;
          end else if (to_hit) begin
            err_q <= 1'b1;
            stb_q <= '0;
            state <= BUS_RESP;
          end
        end
        BUS_RESP: begin
          rdata_q <= '0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state   <= BUS_IDLE;
        end
        default: begin
          rdata_q <= '0;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          stb_q   <= '0;
          state   <= BUS_IDLE;
        end
      endcase
    end
  end

  assign bus.m_data_o = rdata_q;
  assign bus.m_ack_o  = ack_q;
  assign bus.m_err_o  = err_q;
  assign bus.s_addr_o = addr_q;
  assign bus.s_data_o = wdata_q;
  assign bus.s_we_o   = we_q;
  assign bus.s_sel_o  = sel_q;
  assign bus.s_stb_o  = stb_q;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: an 8-slave and a 5-slave instance, TIMEOUT=4,
// expected responses queued at request time and popped when ack/err appears.
module tb_bus_arbiter_n;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] data;
    int          lat;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    t_acc = 0;
  resp_t sbq[$];

  always #5 clk = ~clk;

  bus_arbiter_n_if #(.NUM_SLAVES(8), .ADDR_W(32), .DATA_W(32)) bus8 ();
  bus_arbiter_n_if #(.NUM_SLAVES(5), .ADDR_W(32), .DATA_W(32)) bus5 ();

  bus_arbiter_n #(.NUM_SLAVES(8), .TIMEOUT(4)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.master));
  bus_arbiter_n #(.NUM_SLAVES(5), .TIMEOUT(4)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5.master));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req8(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
    bus8.m_addr_i = a;
    bus8.m_data_i = d;
    bus8.m_we_i   = we;
    bus8.m_sel_i  = sel;
    bus8.m_stb_i  = 1'b1;
    t_acc = cyc;
  endtask

  task automatic slave8(input int k, input logic [31:0] d);
    bus8.s_ack_i = 8'(1 << k);
    bus8.s_data_i[k*32 +: 32] = d;
  endtask

  task automatic check_idle(input string tag, input bit which);
    if (which) begin
      chk({tag, "_stb"},  64'(bus5.s_stb_o),  64'd0);
      chk({tag, "_ack"},  64'(bus5.m_ack_o),  64'd0);
      chk({tag, "_err"},  64'(bus5.m_err_o),  64'd0);
      chk({tag, "_addr"}, 64'(bus5.s_addr_o), 64'd0);
    end else begin
      chk({tag, "_stb"},  64'(bus8.s_stb_o),  64'd0);
      chk({tag, "_ack"},  64'(bus8.m_ack_o),  64'd0);
      chk({tag, "_err"},  64'(bus8.m_err_o),  64'd0);
      chk({tag, "_addr"}, 64'(bus8.s_addr_o), 64'd0);
    end
  endtask

  // Wait (bounded) for ack/err, compare against the oldest queued expectation, then
  // release the request and confirm the response was a single-cycle pulse.
  task automatic collect(input string tag, input bit which, input int budget);
    resp_t       e;
    int          n;
    logic        a, er;
    logic [31:0] d;
    n  = 0;
    a  = which ? bus5.m_ack_o  : bus8.m_ack_o;
    er = which ? bus5.m_err_o  : bus8.m_err_o;
    while (!(a | er) && n < budget) begin
      tick();
      n++;
      a  = which ? bus5.m_ack_o : bus8.m_ack_o;
      er = which ? bus5.m_err_o : bus8.m_err_o;
    end
    d = which ? bus5.m_data_o : bus8.m_data_o;
    if (sbq.size() == 0) begin
      e = '{1'b0, 1'b0, 32'd0, -1};
    end else begin
      e = sbq.pop_front();
    end
    chk({tag, "_ack"},  64'(a),           64'(e.ack));
    chk({tag, "_err"},  64'(er),          64'(e.err));
    chk({tag, "_data"}, 64'(d),           64'(e.data));
    chk({tag, "_lat"},  64'(cyc - t_acc), 64'(e.lat));
    bus8.m_stb_i = 1'b0;
    bus5.m_stb_i = 1'b0;
    bus8.s_ack_i = '0;
    bus5.s_ack_i = '0;
    tick();
    a  = which ? bus5.m_ack_o  : bus8.m_ack_o;
    er = which ? bus5.m_err_o  : bus8.m_err_o;
    d  = which ? bus5.m_data_o : bus8.m_data_o;
    chk({tag, "_pulse"}, {62'd0, a, er}, 64'd0);
    chk({tag, "_dclr"},  64'(d),         64'd0);
  endtask

  initial begin
    bus8.m_addr_i = '0; bus8.m_data_i = '0; bus8.m_we_i = 1'b0; bus8.m_sel_i = '0;
    bus8.m_stb_i  = 1'b0; bus8.s_data_i = '0; bus8.s_ack_i = '0;
    bus5.m_addr_i = '0; bus5.m_data_i = '0; bus5.m_we_i = 1'b0; bus5.m_sel_i = '0;
    bus5.m_stb_i  = 1'b0; bus5.s_data_i = '0; bus5.s_ack_i = '0;

    // Reset state
    tick(); tick();
    check_idle("rst8", 1'b0);
    check_idle("rst5", 1'b1);
    chk("rst8_data", 64'(bus8.m_data_o), 64'd0);
    rst = 1'b1;
    tick();

    // 1: read slave 2, ack in the first strobe cycle
    req8(32'h2000_0010, 32'h0, 1'b0, 4'hF);
    sbq.push_back('{1'b1, 1'b0, 32'hCAFE_0002, 2});
    tick();
    chk("t1_stb", 64'(bus8.s_stb_o), 64'h04);
    chk("t1_addr", 64'(bus8.s_addr_o), 64'h2000_0010);
    slave8(2, 32'hCAFE_0002);
    tick();
    chk("t1_stbclr", 64'(bus8.s_stb_o), 64'h00);
    collect("t1", 1'b0, 4);

    // 2: write slave 7, ack after 3 wait cycles; slave data must not leak to m_data_o
    req8(32'h7000_0000, 32'h1234_5678, 1'b1, 4'b0011);
    sbq.push_back('{1'b1, 1'b0, 32'h0, 5});
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_stb", 64'(bus8.s_stb_o), 64'h80);
      tick();
    end
    chk("t2_we",   64'(bus8.s_we_o),   64'd1);
    chk("t2_sel",  64'(bus8.s_sel_o),  64'h3);
    chk("t2_wdat", 64'(bus8.s_data_o), 64'h1234_5678);
    chk("t2_noack", 64'(bus8.m_ack_o), 64'd0);
    slave8(7, 32'hFFFF_FFFF);
    tick();
    collect("t2", 1'b0, 4);

    // 3: decode error on the 5-slave instance
    bus5.m_addr_i = 32'h6000_0000;
    bus5.m_we_i   = 1'b0;
    bus5.m_sel_i  = 4'hF;
    bus5.m_stb_i  = 1'b1;
    t_acc = cyc;
    sbq.push_back('{1'b0, 1'b1, 32'h0, 1});
    tick();
    chk("t3_stb", 64'(bus5.s_stb_o), 64'h00);
    collect("t3", 1'b1, 4);

`ifdef BUS_TIMEOUT_EN
    // 4a: silent slave 4 times out after four strobe cycles
    req8(32'h4000_0000, 32'h0, 1'b0, 4'hF);
    sbq.push_back('{1'b0, 1'b1, 32'h0, 5});
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t4a_stb", 64'(bus8.s_stb_o), 64'h10);
      tick();
    end
    chk("t4a_stbclr", 64'(bus8.s_stb_o), 64'h00);
    collect("t4a", 1'b0, 4);

    // 4b: ack in the timeout cycle wins
    req8(32'h4000_0000, 32'h0, 1'b0, 4'hF);
    sbq.push_back('{1'b1, 1'b0, 32'h0000_0044, 5});
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t4b_stb", 64'(bus8.s_stb_o), 64'h10);
      tick();
    end
    slave8(4, 32'h0000_0044);
    tick();
    collect("t4b", 1'b0, 4);
`else
    // 4: without the timeout, a silent slave is waited on indefinitely
    req8(32'h4000_0000, 32'h0, 1'b0, 4'hF);
    sbq.push_back('{1'b1, 1'b0, 32'h0000_0044, 8});
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t4_stb", {62'd0, bus8.m_err_o, 1'b0}, 64'd0);
      chk("t4_hold", 64'(bus8.s_stb_o), 64'h10);
      tick();
    end
    slave8(4, 32'h0000_0044);
    tick();
    collect("t4", 1'b0, 4);
`endif

    // 5: stray ack from slave 3 during a slave 1 access is ignored
    req8(32'h1000_0000, 32'h0, 1'b0, 4'hF);
    sbq.push_back('{1'b1, 1'b0, 32'hA5A5_A5A5, 3});
    tick();
    slave8(3, 32'hDEAD_BEEF);
    tick();
    chk("t5_stray_stb", 64'(bus8.s_stb_o), 64'h02);
    chk("t5_stray_ack", 64'(bus8.m_ack_o), 64'd0);
    slave8(1, 32'hA5A5_A5A5);
    tick();
    collect("t5", 1'b0, 4);

    // 6: asynchronous reset mid-ACCESS abandons the request
    req8(32'h3000_0020, 32'h0, 1'b0, 4'hF);
    tick();
    chk("t6_stb", 64'(bus8.s_stb_o), 64'h08);
    #2;
    rst = 1'b0;
    #1;
    check_idle("t6_rst", 1'b0);
    bus8.m_stb_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    req8(32'h0000_0004, 32'h0, 1'b0, 4'hF);
    sbq.push_back('{1'b1, 1'b0, 32'h0BAD_F00D, 2});
    tick();
    chk("t6_stb0", 64'(bus8.s_stb_o), 64'h01);
    slave8(0, 32'h0BAD_F00D);
    tick();
    collect("t6", 1'b0, 4);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
- Parametrised successor of the fixed 8-slave system bus.
- One master port to NUM_SLAVES slave ports.
- Decodes a configurable address field, forwards one registered transaction at a time, and returns a registered ack or error.
- Adds decode-error and (optional) timeout-error responses, byte selects and a strobe-qualified handshake.

Parameters:
NUM_SLAVES, 8, number of slave ports (1..2^SEL_BITS)
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
SEL_LSB, 28, lowest address bit of slave-index field
SEL_BITS, 3, width of slave-index field
TIMEOUT, 255, cycles in ACCESS before timeout error (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
m_addr_i  in  ADDR_W  master address
m_data_i  in  DATA_W  master write data
m_we_i  in  1  1=write, 0=read
m_sel_i  in  DATA_W/8  byte enables
m_stb_i  in  1  request valid, held until m_ack_o or m_err_o
m_data_o  out  DATA_W  read data, valid with m_ack_o
m_ack_o  out  1  one-cycle success pulse
m_err_o  out  1  one-cycle error pulse
s_addr_o  out  ADDR_W  latched address, shared by all slaves
s_data_o  out  DATA_W  latched write data, shared by all slaves
s_we_o  out  1  latched write enable, shared by all slaves
s_sel_o  out  DATA_W/8  latched byte enables, shared by all slaves
s_stb_o  out  NUM_SLAVES  one-hot strobe to the addressed slave
s_data_i  in  NUM_SLAVES*DATA_W  flattened read data; slave k at bits [k*DATA_W +: DATA_W]
s_ack_i  in  NUM_SLAVES  per-slave ack

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; timeout counter 0.
  - Takes effect immediately, including mid-transaction. The in-flight request is abandoned with no ack or err.
- All outputs are registered.
- IDLE:
  - On m_stb_i=1, latch addr/data/we/sel into the s_* registers and compute idx = m_addr_i[SEL_LSB +: SEL_BITS].
  - If idx < NUM_SLAVES: set s_stb_o = 1<<idx and go to ACCESS.
  - Otherwise go to RESP with err flag set; no slave is strobed.
- ACCESS:
  - s_stb_o held; s_* stable.
  - On s_ack_i[idx]=1: capture s_data_i slice idx into m_data_o; clear s_stb_o; go to RESP with ack flag.
  - s_ack_i of non-selected slaves is ignored.
  - The timeout counter increments each ACCESS cycle without ack (see optional feature).
- RESP:
  - Exactly one cycle. m_ack_o=1 or m_err_o=1, never both.
  - m_data_o holds read data on ack; it is 0 on err and on writes.
  - Next state is IDLE. Ack/err and m_data_o return to 0.
- Latency:
  - Request accepted at edge E0; s_stb_o high in the cycle after E0.
  - If the slave acks in that cycle, m_ack_o is high in the cycle after E1. Minimum 2 cycles, accept to ack.
  - Decode error: m_err_o is high in the cycle after E0.
- Master rule: deassert or change m_stb_i in the cycle following the ack/err pulse.
  - IDLE samples m_stb_i again only after RESP, so back-to-back requests are spaced by one IDLE cycle minimum.
- Changes on m_* during ACCESS are ignored because requests are latched.
- s_data_o and s_addr_o keep their last values in IDLE; only s_stb_o qualifies them.
- NUM_SLAVES=1 is legal; only idx 0 decodes.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter (width clog2(TIMEOUT+1)) clears on entering ACCESS.
  - When it reaches TIMEOUT with no ack, s_stb_o clears and the block goes to RESP with err.
  - An ack arriving in the same cycle as the timeout wins, and ack is returned.
- Undefined: no counter; ACCESS waits indefinitely for the ack.

Decomposition:
- defines.v holds:
  - state encodings BUS_IDLE / BUS_ACCESS / BUS_RESP;
  - default widths WB_AddrBus / WB_DataBus / WB_SelectBus;
  - the BUS_TIMEOUT_EN guard.
- One sub-module, bus_addr_decode (combinational):
  - inputs: address, NUM_SLAVES, SEL_LSB, SEL_BITS;
  - outputs: one-hot vector and valid flag.

Test Plan:
1. Read slave 2 (NUM_SLAVES=8): m_addr_i=0x2000_0010, stb; slave 2 acks on first strobe cycle with 0xCAFE_0002 -> s_stb_o=0x04 one cycle, then m_ack_o=1 with m_data_o=0xCAFE_0002 exactly 2 cycles after accept.
2. Write slave 7: addr 0x7000_0000, data 0x1234_5678, sel=4'b0011 -> s_stb_o=0x80, s_we_o=1, s_sel_o=0011, s_data_o=0x1234_5678; ack after 3 wait cycles -> single m_ack_o, m_data_o=0.
3. Decode error (NUM_SLAVES=5): addr 0x6000_0000 -> s_stb_o stays 0; m_err_o=1 one cycle after accept.
4. Timeout (BUS_TIMEOUT_EN, TIMEOUT=4): slave never acks -> s_stb_o high 4 cycles, then m_err_o=1. Repeat with ack on cycle 4 -> m_ack_o, no err.
5. Stray ack: during a slave 1 access, pulse s_ack_i[3] -> ignored. Then s_ack_i[1] with 0xA5A5_A5A5 -> that value returned.
6. Reset mid-ACCESS: drive rst=0 asynchronously -> s_stb_o, m_ack_o and m_err_o are 0 immediately. After release, a new read to slave 0 completes normally.
